// File: rtl/systolic_row_skewer_if.sv
// rtl/systolic_row_skewer_if.sv - row input handshake and skewed lane outputs
interface systolic_row_skewer_if #(
  parameter int N  = 4,
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [N*DW-1:0] in_data;
  logic          in_last;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]  out_valid;
  logic          busy;
  logic          done;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_data, out_valid, busy, done
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/systolic_row_skewer.sv
// rtl/systolic_row_skewer.sv - row FIFO plus diagonal lane skew feeder for a systolic row
module systolic_row_skewer #(
  parameter int N     = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  systolic_row_skewer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] FLUSH_LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t state, state_nx;

  // Each FIFO entry is {last, row}
  logic [N*DW:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [CW-1:0]   flush_cnt;
  logic            rdy_q;
  logic            full, empty, push, pop, ready;
  logic            head_last;
  logic [N*DW-1:0] head_data;
  logic [N*DW-1:0] issue_data;
  logic            issue_valid;
  logic [N*DW-1:0] lane_data;
  logic [N-1:0]    lane_valid;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  // Ready comes only from registers so the source never sees a pop-to-ready path
  assign ready     = rdy_q & ~full;
  assign push      = bus.in_valid & ready;
  assign head_last = mem[rd_ptr][N*DW];
  assign head_data = mem[rd_ptr][N*DW-1:0];

  assign bus.in_ready  = ready;
  assign bus.out_data  = lane_data;
  assign bus.out_valid = lane_valid;
  assign bus.busy      = (state != IDLE) | ~empty;
  // Lane N-1 shows the tile's last row exactly on the final flush cycle
  assign bus.done      = (state == FLUSH) && (flush_cnt == FLUSH_LAST);

  // Next-state and pop decision; a popped row is issued on the same edge
  always_comb begin
    state_nx    = state;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = head_last ? FLUSH : STREAM;
        end
      end
      STREAM: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_last) state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_cnt == FLUSH_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    issue_valid = pop;
    issue_data  = pop ? head_data : '0;
  end

  // FSM state and flush counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nx;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
    end
  end

  // FIFO pointers, occupancy and the post-reset ready enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // FIFO storage; contents are only observed through non-empty pops
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_last, bus.in_data};
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] dly_d [i+1];
    logic          dly_v [i+1];

    // Lane i delays its word by i+1 registers so wavefronts form a diagonal
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 0; k <= i; k++) begin
          dly_d[k] <= '0;
          dly_v[k] <= 1'b0;
        end
      end else begin
        dly_d[0] <= issue_data[i*DW +: DW];
        dly_v[0] <= issue_valid;
        for (int k = 1; k <= i; k++) begin
          dly_d[k] <= dly_d[k-1];
          dly_v[k] <= dly_v[k-1];
        end
      end
    end

    assign lane_data[i*DW +: DW] = dly_d[i];
    assign lane_valid[i]         = dly_v[i];
  end

endmodule
